// File: rtl/seven_segment_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller.
package seven_segment_pkg;

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned IDX_W         = $clog2(NUM_DIGITS);
    localparam logic [6:0]  SEG_BLANK     = 7'b0000000;
    localparam logic [3:0]  DIGIT_ALL_OFF = 4'b1111;

endpackage

// File: rtl/bcd_seven_segment_mapping.sv
// Hex nibble to active-high abcdefg segment pattern (combinational).
module bcd_seven_segment_mapping
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments_c
);

    // Segment lookup, MSB = a ... LSB = g
    always_comb begin
        segments_c = SEG_BLANK;
        case (nibble)
            4'h0: segments_c = 7'b1111110;
            4'h1: segments_c = 7'b0110000;
            4'h2: segments_c = 7'b1101101;
            4'h3: segments_c = 7'b1111001;
            4'h4: segments_c = 7'b0110011;
            4'h5: segments_c = 7'b1011011;
            4'h6: segments_c = 7'b1011111;
            4'h7: segments_c = 7'b1110000;
            4'h8: segments_c = 7'b1111111;
            4'h9: segments_c = 7'b1111011;
            4'hA: segments_c = 7'b1110111;
            4'hB: segments_c = 7'b0011111;
            4'hC: segments_c = 7'b1001110;
            4'hD: segments_c = 7'b0111101;
            4'hE: segments_c = 7'b1001111;
            4'hF: segments_c = 7'b1000111;
            default: segments_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with anti-ghost blanking and
// frame-synchronous (tear-free) value update.
// Optional: define SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int unsigned P_SHOW_CYCLES  = 50000,
    parameter int unsigned P_BLANK_CYCLES = 1000
) (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic        I_ENABLE,
    input  logic        I_LOAD,
    input  logic [15:0] I_VALUE,
    output logic        O_LOAD_PENDING,
    output logic [3:0]  O_DIGIT_EN_N,
    output logic [6:0]  O_SEGMENTS
);

    localparam int unsigned CNT_MAX = (P_SHOW_CYCLES > P_BLANK_CYCLES) ? P_SHOW_CYCLES
                                                                       : P_BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(P_SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(P_BLANK_CYCLES - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               active, active_nx;
    logic [15:0]        shadow, display, display_nx;
    logic               frame_edge_c, xfer_c, lz_blank_c;
    logic [3:0]         nibble_nx;
    logic [6:0]         seg_dec_c;

    // Scan sequencing: next state, digit index, dwell counter
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        active_nx = active;
        if (!I_ENABLE) begin
            state_nx  = S_BLANK;
            idx_nx    = '0;
            cnt_nx    = '0;
            active_nx = 1'b0;
        end else if (!active) begin
            state_nx  = S_SHOW;
            idx_nx    = '0;
            cnt_nx    = '0;
            active_nx = 1'b1;
        end else if (state == S_SHOW) begin
            if (cnt == SHOW_LAST) begin
                state_nx = S_BLANK;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end else begin
            if (cnt == BLANK_LAST) begin
                state_nx = S_SHOW;
                cnt_nx   = '0;
                idx_nx   = idx + 1'b1;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    // Shadow-to-display transfer happens only at a frame boundary or while idle
    assign frame_edge_c = (state != S_SHOW) && (state_nx == S_SHOW) && (idx_nx == '0);
    assign xfer_c       = O_LOAD_PENDING && (frame_edge_c || !I_ENABLE);
    assign display_nx   = xfer_c ? shadow : display;
    assign nibble_nx    = display_nx[{idx_nx, 2'b00} +: 4];

    bcd_seven_segment_mapping u_map (
        .nibble     (nibble_nx),
        .segments_c (seg_dec_c)
    );

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    // Blank digit n (n >= 1) when it and every more significant nibble are zero
    always_comb begin
        lz_blank_c = 1'b0;
        case (idx_nx)
            2'd3:    lz_blank_c = (display_nx[15:12] == 4'h0);
            2'd2:    lz_blank_c = (display_nx[15:8]  == 8'h00);
            2'd1:    lz_blank_c = (display_nx[15:4]  == 12'h000);
            default: lz_blank_c = 1'b0;
        endcase
    end
`else
    assign lz_blank_c = 1'b0;
`endif

    // State, value registers and registered display outputs
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state          <= S_BLANK;
            idx            <= '0;
            cnt            <= '0;
            active         <= 1'b0;
            shadow         <= 16'h0000;
            display        <= 16'h0000;
            O_LOAD_PENDING <= 1'b0;
            O_DIGIT_EN_N   <= DIGIT_ALL_OFF;
            O_SEGMENTS     <= SEG_BLANK;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            active  <= active_nx;
            display <= display_nx;
            if (I_LOAD) begin
                shadow         <= I_VALUE;
                O_LOAD_PENDING <= 1'b1;
            end else if (xfer_c) begin
                O_LOAD_PENDING <= 1'b0;
            end
            if (state_nx == S_SHOW) begin
                O_DIGIT_EN_N <= ~(4'b0001 << idx_nx);
                O_SEGMENTS   <= lz_blank_c ? SEG_BLANK : seg_dec_c;
            end else begin
                O_DIGIT_EN_N <= DIGIT_ALL_OFF;
                O_SEGMENTS   <= SEG_BLANK;
            end
        end
    end

endmodule
